// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like bus arbiter: owner IDs, size encodings, defaults.
package sram_like_pkg;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int unsigned DEFAULT_OUTSTANDING = 2;
    localparam int unsigned DEFAULT_CNT_W       = 2;

endpackage

// File: rtl/owner_fifo.sv
// In-order queue of 1-bit owner IDs for accepted-but-unanswered transactions.
module owner_fifo
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_OUTSTANDING,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id;
                wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master round-robin arbiter onto one sram-like slave, with in-order response routing.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int unsigned OUTSTANDING = DEFAULT_OUTSTANDING,
    parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,

    output logic        err_unexp
);

    logic             lock_q, lock_id_q, last_grant_q, err_q;
    logic             lock_eff, grant, accept, resp_valid, owner;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // A lock only holds while its master keeps requesting; a dropped request releases it.
    assign lock_eff = lock_q && ((lock_id_q == OWN_M1) ? m1_req : m0_req);

    always_comb begin
        grant = OWN_M0;
        if (lock_eff) begin
            grant = lock_id_q;
        end else if (m0_req && !m1_req) begin
            grant = OWN_M0;
        end else if (m1_req && !m0_req) begin
            grant = OWN_M1;
        end else if (m0_req && m1_req) begin
            grant = ~last_grant_q;
        end
    end

    assign s_req  = !reset && !fifo_full && (m0_req || m1_req);
    assign accept = s_req && s_addr_ok;

    always_comb begin
        s_wr    = 1'b0;
        s_size  = '0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (s_req) begin
            if (grant == OWN_M1) begin
                s_wr    = m1_wr;
                s_size  = m1_size;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_wstrb = m1_wstrb;
            end else begin
                s_wr    = m0_wr;
                s_size  = m0_size;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_wstrb = m0_wstrb;
            end
        end
    end

    assign m0_addr_ok = accept && (grant == OWN_M0);
    assign m1_addr_ok = accept && (grant == OWN_M1);

    assign resp_valid = s_data_ok && (fifo_count != '0);
    assign m0_data_ok = resp_valid && (owner == OWN_M0);
    assign m1_data_ok = resp_valid && (owner == OWN_M1);
    assign m0_rdata   = m0_data_ok ? s_rdata : '0;
    assign m1_rdata   = m1_data_ok ? s_rdata : '0;
    assign err_unexp  = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_id_q    <= OWN_M0;
            last_grant_q <= OWN_M1;
            err_q        <= 1'b0;
        end else begin
            lock_q <= s_req && !s_addr_ok;
            if (s_req && !s_addr_ok) begin
                lock_id_q <= grant;
            end
            if (accept) begin
                last_grant_q <= grant;
            end
            if (s_data_ok && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    owner_fifo #(
        .DEPTH (OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_owner_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .push_id (grant),
        .pop     (resp_valid),
        .head    (owner),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Cycle-vector bench for sram_like_arbiter with a queue of expected per-cycle outputs.
module tb_sram_like_arbiter;
    import sram_like_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        err_unexp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(
        .OUTSTANDING (2),
        .CNT_W       (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_size    (m0_size),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_wstrb   (m0_wstrb),
        .m0_addr_ok (m0_addr_ok),
        .m0_data_ok (m0_data_ok),
        .m0_rdata   (m0_rdata),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_size    (m1_size),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_wstrb   (m1_wstrb),
        .m1_addr_ok (m1_addr_ok),
        .m1_data_ok (m1_data_ok),
        .m1_rdata   (m1_rdata),
        .s_req      (s_req),
        .s_wr       (s_wr),
        .s_size     (s_size),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_addr_ok  (s_addr_ok),
        .s_data_ok  (s_data_ok),
        .s_rdata    (s_rdata),
        .err_unexp  (err_unexp)
    );

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] ad0, ad1;
        logic        sao, sdo;
        logic [31:0] srd;
        logic        e_sreq, e_swr;
        logic [31:0] e_saddr;
        logic        e_a0, e_a1, e_d0, e_d1;
        logic [31:0] e_rd0, e_rd1;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(
        input logic r0, input logic r1, input logic w0, input logic w1,
        input logic [31:0] ad0, input logic [31:0] ad1,
        input logic sao, input logic sdo, input logic [31:0] srd,
        input logic e_sreq, input logic e_swr, input logic [31:0] e_saddr,
        input logic e_a0, input logic e_a1, input logic e_d0, input logic e_d1,
        input logic [31:0] e_rd0, input logic [31:0] e_rd1, input logic e_err);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.ad0 = ad0; v.ad1 = ad1;
        v.sao = sao; v.sdo = sdo; v.srd = srd;
        v.e_sreq = e_sreq; v.e_swr = e_swr; v.e_saddr = e_saddr;
        v.e_a0 = e_a0; v.e_a1 = e_a1; v.e_d0 = e_d0; v.e_d1 = e_d1;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        m0_req = v.r0; m1_req = v.r1; m0_wr = v.w0; m1_wr = v.w1;
        m0_addr = v.ad0; m1_addr = v.ad1;
        m0_wdata = ~v.ad0; m1_wdata = v.ad1 ^ 32'hF0F0_F0F0;
        s_addr_ok = v.sao; s_data_ok = v.sdo; s_rdata = v.srd;
    endtask

    task automatic compare(input int i, input vec_t e);
        logic        g1;
        logic [31:0] exp_wdata;
        logic [1:0]  exp_size;
        logic [3:0]  exp_strb;
        string       p;
        p  = $sformatf("v%0d", i);
        g1 = e.e_sreq && (e.e_saddr == e.ad1);
        exp_wdata = !e.e_sreq ? 32'h0 : (g1 ? (e.ad1 ^ 32'hF0F0_F0F0) : ~e.ad0);
        exp_size  = !e.e_sreq ? 2'd0 : (g1 ? SZ_H : SZ_W);
        exp_strb  = !e.e_sreq ? 4'h0 : (g1 ? 4'h3 : 4'hF);
        chk1 ({p, " s_req"}, s_req, e.e_sreq);
        chk1 ({p, " s_wr"}, s_wr, e.e_swr);
        chk32({p, " s_addr"}, s_addr, e.e_saddr);
        chk32({p, " s_wdata"}, s_wdata, exp_wdata);
        chk32({p, " s_size"}, {30'd0, s_size}, {30'd0, exp_size});
        chk32({p, " s_wstrb"}, {28'd0, s_wstrb}, {28'd0, exp_strb});
        chk1 ({p, " m0_addr_ok"}, m0_addr_ok, e.e_a0);
        chk1 ({p, " m1_addr_ok"}, m1_addr_ok, e.e_a1);
        chk1 ({p, " m0_data_ok"}, m0_data_ok, e.e_d0);
        chk1 ({p, " m1_data_ok"}, m1_data_ok, e.e_d1);
        chk32({p, " m0_rdata"}, m0_rdata, e.e_rd0);
        chk32({p, " m1_rdata"}, m1_rdata, e.e_rd1);
        chk1 ({p, " err_unexp"}, err_unexp, e.e_err);
    endtask

    initial begin
        vec_t zero_v;
        vec_t got;
        zero_v = mk(0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0, 0);

        // Idle
        vecs.push_back(zero_v);
        // Both requesting: m0 first, then alternating; responses overlap accepts
        vecs.push_back(mk(1,1,0,0, 32'h100,32'h200, 1,0,0,
                          1,0,32'h100, 1,0,0,0, 0,0, 0));
        vecs.push_back(mk(1,1,0,0, 32'h104,32'h204, 1,1,32'h11,
                          1,0,32'h204, 0,1,1,0, 32'h11,0, 0));
        vecs.push_back(mk(1,1,0,0, 32'h108,32'h208, 1,1,32'h22,
                          1,0,32'h108, 1,0,0,1, 0,32'h22, 0));
        vecs.push_back(mk(1,1,0,0, 32'h10C,32'h20C, 1,1,32'h33,
                          1,0,32'h20C, 0,1,1,0, 32'h33,0, 0));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,1,32'h44,
                          0,0,0, 0,0,0,1, 0,32'h44, 0));
        // Lock: m1 write waits for addr_ok while m0 also requests
        vecs.push_back(mk(0,1,0,1, 0,32'h20, 0,0,0,
                          1,1,32'h20, 0,0,0,0, 0,0, 0));
        vecs.push_back(mk(1,1,0,1, 32'h30,32'h20, 0,0,0,
                          1,1,32'h20, 0,0,0,0, 0,0, 0));
        vecs.push_back(mk(1,1,0,1, 32'h30,32'h20, 0,0,0,
                          1,1,32'h20, 0,0,0,0, 0,0, 0));
        vecs.push_back(mk(1,1,0,1, 32'h30,32'h20, 1,0,0,
                          1,1,32'h20, 0,1,0,0, 0,0, 0));
        vecs.push_back(mk(1,0,0,1, 32'h30,32'h20, 1,0,0,
                          1,0,32'h30, 1,0,0,0, 0,0, 0));
        // Full: no request while two are outstanding, even across the pop cycle
        vecs.push_back(mk(1,1,0,0, 32'h34,32'h24, 1,0,0,
                          0,0,0, 0,0,0,0, 0,0, 0));
        vecs.push_back(mk(1,1,0,0, 32'h34,32'h24, 1,1,32'hAAAA_0001,
                          0,0,0, 0,0,0,1, 0,32'hAAAA_0001, 0));
        vecs.push_back(mk(1,1,0,0, 32'h34,32'h24, 1,0,0,
                          1,0,32'h24, 0,1,0,0, 0,0, 0));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,1,32'hBBBB_0002,
                          0,0,0, 0,0,1,0, 32'hBBBB_0002,0, 0));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,1,32'hCCCC_0003,
                          0,0,0, 0,0,0,1, 0,32'hCCCC_0003, 0));
        // Locked master drops its request: m0 gets through
        vecs.push_back(mk(0,1,0,0, 0,32'h40, 0,0,0,
                          1,0,32'h40, 0,0,0,0, 0,0, 0));
        vecs.push_back(mk(1,0,0,0, 32'h50,32'h40, 1,0,0,
                          1,0,32'h50, 1,0,0,0, 0,0, 0));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,1,32'h1234,
                          0,0,0, 0,0,1,0, 32'h1234,0, 0));
        // Single m0 read
        vecs.push_back(mk(1,0,0,0, 32'h1000,0, 1,0,0,
                          1,0,32'h1000, 1,0,0,0, 0,0, 0));
        vecs.push_back(zero_v);
        vecs.push_back(mk(0,0,0,0, 0,0, 0,1,32'hDEAD_BEEF,
                          0,0,0, 0,0,1,0, 32'hDEAD_BEEF,0, 0));
        // Unexpected response with empty queue
        vecs.push_back(mk(0,0,0,0, 0,0, 0,1,32'h55,
                          0,0,0, 0,0,0,0, 0,0, 0));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,
                          0,0,0, 0,0,0,0, 0,0, 1));
        vecs.push_back(mk(0,1,0,0, 0,32'h60, 1,0,0,
                          1,0,32'h60, 0,1,0,0, 0,0, 1));

        m0_size = SZ_W; m1_size = SZ_H; m0_wstrb = 4'hF; m1_wstrb = 4'h3;
        reset = 1'b1;
        drive(zero_v);
        m0_req = 1'b1; m1_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("reset s_req", s_req, 1'b0);
        chk1("reset m0_addr_ok", m0_addr_ok, 1'b0);
        chk1("reset m1_addr_ok", m1_addr_ok, 1'b0);
        chk1("reset m0_data_ok", m0_data_ok, 1'b0);
        chk1("reset m1_data_ok", m1_data_ok, 1'b0);
        chk1("reset err_unexp", err_unexp, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(zero_v);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            got = exp_q.pop_front();
            compare(i, got);
        end

        // Reset pulse clears the sticky error and discards the pending m1 entry
        @(posedge clk); #1;
        drive(zero_v);
        reset = 1'b1;
        @(negedge clk);
        chk1("pulse err_unexp", err_unexp, 1'b0);
        chk1("pulse s_req", s_req, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        s_data_ok = 1'b1; s_rdata = 32'h77;
        @(negedge clk);
        chk1("stale m1_data_ok", m1_data_ok, 1'b0);
        chk1("stale m0_data_ok", m0_data_ok, 1'b0);
        chk32("stale m1_rdata", m1_rdata, 32'h0);
        @(posedge clk); #1;
        s_data_ok = 1'b0;
        @(negedge clk);
        chk1("stale err_unexp", err_unexp, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like slave port (the data side of the CPU AXI bridge) between two sram-like masters: m0 = MEM-stage load/store, m1 = secondary requester (uncached/debug access).
- Round-robin grant, with the grant locked while a request waits for addr_ok.
- Tracks up to OUTSTANDING accepted transactions in an in-order owner queue and routes each data_ok/rdata back to its owner.

Parameters:
- OUTSTANDING, 2, max accepted-but-unanswered transactions (1..4); owner queue depth.
- CNT_W, 2, width of the outstanding counter; must hold 0..OUTSTANDING.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_req / m1_req  input  1  request valid.
- m0_wr / m1_wr  input  1  1 = write, 0 = read.
- m0_size / m1_size  input  2  0: 1 byte, 1: 2 bytes, 2: 4 bytes.
- m0_addr / m1_addr  input  32  byte address.
- m0_wdata / m1_wdata  input  32  write data.
- m0_wstrb / m1_wstrb  input  4  byte strobes.
- m0_addr_ok / m1_addr_ok  output  1  request accepted this cycle.
- m0_data_ok / m1_data_ok  output  1  response for this master this cycle.
- m0_rdata / m1_rdata  output  32  read data, zero unless own data_ok.
- s_req, s_wr, s_size[2], s_addr[32], s_wdata[32], s_wstrb[4]  output  -  muxed request to the slave.
- s_addr_ok  input  1  slave accepted the request.
- s_data_ok  input  1  slave response; responses return in acceptance order.
- s_rdata  input  32  slave read data.
- err_unexp  output  1  sticky: s_data_ok arrived with the owner queue empty.

Behaviour:
- Reset (async, active-high):
  - Queue empty, count = 0, lock = 0, last_grant = 1 (so m0 wins first), err_unexp = 0.
  - s_req = 0 while reset is high; all addr_ok/data_ok outputs = 0.
- full = (count == OUTSTANDING). When full: s_req = 0 and both addr_ok = 0; master requests stall.
- Grant (combinational):
  - If lock = 1, grant = lock_id.
  - Else, only one master requesting: grant that master.
  - Else, both requesting: grant the master != last_grant.
- Request path:
  - s_req = !full && (m0_req | m1_req).
  - s_wr/size/addr/wdata/wstrb are the granted master's fields; all zero when s_req = 0.
- Acceptance: mX_addr_ok = s_req && s_addr_ok && grant == X. Zero-cycle latency: addr_ok is combinational from s_addr_ok.
- Lock:
  - Set when s_req && !s_addr_ok at a clock edge; lock_id <= grant.
  - Cleared on the accept edge.
  - Cleared if the locked master drops req without acceptance (protocol violation; arbitration then resumes normally).
- On accept edge: last_grant <= grant; push grant into the owner queue; count + 1.
- Response:
  - owner = queue head. mX_data_ok = s_data_ok && count != 0 && owner == X.
  - mX_rdata = s_rdata when own data_ok, else 0.
  - On a data_ok edge with count != 0: pop, count - 1.
- Simultaneous push and pop in one cycle: both happen, count unchanged. Pointers wrap modulo OUTSTANDING.
- Full with a pop this cycle: no push is possible this cycle (s_req is already 0); the request is accepted the next cycle. No combinational path from s_data_ok to s_req.
- s_data_ok with count == 0: no master sees data_ok, no pop, err_unexp <= 1 until reset.
- Reset mid-operation: queue and lock discarded immediately. The slave is reset by the same system reset, so no stale responses are expected; any that arrive set err_unexp.
- Writes and reads share the same queue: the write response (bvalid-derived data_ok) is routed exactly like a read.

Decomposition:
- Shared package sram_like_pkg:
  - Owner IDs: OWN_M0 = 1'b0, OWN_M1 = 1'b1.
  - Size encodings: SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2.
  - Default OUTSTANDING.
- One sub-module: owner_fifo. Synchronous FIFO of 1-bit IDs, depth OUTSTANDING, async active-high reset; push/pop/head/count/full/empty. Instantiated once.

Test Plan:
- Single m0 read: m0_req=1, addr=0x1000, s_addr_ok=1 at cycle 1, s_data_ok=1 at cycle 3 with s_rdata=0xDEADBEEF -> m0_addr_ok=1 at cycle 1; m0_data_ok=1 and m0_rdata=0xDEADBEEF at cycle 3; m1_data_ok=0 throughout.
- Both requesting every cycle, s_addr_ok=1 always -> grants alternate m0, m1, m0, m1, starting with m0; s_addr sequence follows the masters' addresses.
- Lock: m1 alone requests write addr=0x20 with s_addr_ok=0 for 3 cycles, m0 raises req at cycle 1 -> s_addr stays 0x20 with s_wr=1 until accept; m0 granted the next cycle.
- Full: OUTSTANDING=2, two accepts with no data_ok -> s_req=0 while a third request is pending. One s_data_ok -> s_req=1 the following cycle; responses are routed to owners in order m0, m1.
- Same-cycle push/pop: count=1; accept and s_data_ok in the same cycle -> count stays 1; head advances to the new owner.
- Unexpected response: s_data_ok=1 with an empty queue -> both data_ok=0, err_unexp=1 and holds until reset pulses high, then 0.
